// File: rtl/mips_pkg.sv
// Shared definitions for the parametrised select/pipeline blocks.
//   state_e   : handshake stage occupancy (EMPTY / ONE / FULL)
//   sel_width : select-index width for an N-way mux (at least 1 bit)
package mips_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // nothing held
        ST_ONE   = 2'd1,   // main register valid
        ST_FULL  = 2'd2    // main and skid registers valid
    } state_e;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_pipe_if.sv
// Bundle of the mux_pipe upstream/downstream handshake signals.
//   slave  : seen by mux_pipe (takes in_*, flush, out_ready; drives in_ready, out_*)
//   master : seen by the environment driving and consuming the stage
interface mux_pipe_if
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SEL_W = sel_width(N);

    logic [N*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic [WIDTH-1:0]   out_data;
    logic               out_sel_err;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel_err, out_valid
    );

    modport master (
        output in_data, in_sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel_err, out_valid
    );
endinterface

// File: rtl/mux_sel.sv
// Purely combinational N-way WIDTH-bit selector.
//   in_data_i : flattened inputs, input k = in_data_i[k*WIDTH +: WIDTH]
//   sel_i     : index to select
//   data_o    : selected input (input 0 when sel_i is out of range)
//   err_o     : sel_i >= N
module mux_sel
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic [N*WIDTH-1:0] in_data_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               err_o
);

    always_comb begin
        data_o = in_data_i[0 +: WIDTH];
        err_o  = (int'(sel_i) >= N);
        // Out-of-range indices fall through to input 0 rather than aliasing.
        for (int k = 1; k < N; k++) begin
            if (int'(sel_i) == k) data_o = in_data_i[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/mux_pipe.sv
// N-way selector feeding a registered valid/ready stage with a 1-entry skid.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : handshake bundle (in_data/in_sel/in_valid/in_ready, flush,
//          out_data/out_sel_err/out_valid/out_ready)
// in_ready depends only on registered state, so out_ready never reaches
// upstream combinationally; the skid absorbs the word accepted during the
// cycle the downstream first stalls.
module mux_pipe
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux_pipe_if.slave     bus
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    mux_sel #(.WIDTH(WIDTH), .N(N)) u_sel (
        .in_data_i (bus.in_data),
        .sel_i     (bus.in_sel),
        .data_o    (sel_data),
        .err_o     (sel_err)
    );

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             main_err_q, skid_err_q;
    logic             load_main_sel, load_main_skid, load_skid;
    logic             accept, pop;

    assign bus.in_ready    = !rst && (state_q != ST_FULL);
    assign bus.out_valid   = (state_q != ST_EMPTY);
    assign bus.out_data    = main_q;
    assign bus.out_sel_err = main_err_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_sel  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.flush) begin
            // Flush wins over a same-cycle accept; the offered word is dropped.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d       = ST_ONE;
                        load_main_sel = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        load_main_sel = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d        = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            main_err_q <= 1'b0;
            skid_q     <= '0;
            skid_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_main_sel) begin
                main_q     <= sel_data;
                main_err_q <= sel_err;
            end else if (load_main_skid) begin
                main_q     <= skid_q;
                main_err_q <= skid_err_q;
            end
            if (load_skid) begin
                skid_q     <= sel_data;
                skid_err_q <= sel_err;
            end
        end
    end

endmodule

// File: tb/tb_mux_pipe.sv
module tb_mux_pipe;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_pipe_if #(.WIDTH(32), .N(4)) bif4 ();
    mux_pipe_if #(.WIDTH(32), .N(3)) bif3 ();

    mux_pipe #(.WIDTH(32), .N(4)) dut4 (.clk(clk), .rst(rst), .bus(bif4));
    mux_pipe #(.WIDTH(32), .N(3)) dut3 (.clk(clk), .rst(rst), .bus(bif3));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] sb[$];
    logic [31:0] lanes[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One random cycle on the N=4 instance, modelled as a 2-deep FIFO.
    task automatic rnd_step(input logic iv, input logic ordy);
        int          sz = sb.size();
        logic [1:0]  s  = 2'($urandom_range(0, 3));
        logic        pv = bif4.out_valid;
        logic [31:0] pd = bif4.out_data;
        for (int k = 0; k < 4; k++) lanes[k] = $urandom;
        bif4.in_data   = {lanes[3], lanes[2], lanes[1], lanes[0]};
        bif4.in_sel    = s;
        bif4.in_valid  = iv;
        bif4.out_ready = ordy;
        if (sz > 0 && ordy) void'(sb.pop_front());
        if (iv && sz < 2) sb.push_back(lanes[s]);
        tick();
        chk("rnd_out_valid", 32'(bif4.out_valid), 32'(sb.size() != 0));
        chk("rnd_in_ready", 32'(bif4.in_ready), 32'(sb.size() < 2));
        if (pv && !ordy) chk("rnd_hold", bif4.out_data, pd);
        if (sb.size() > 0) chk("rnd_data", bif4.out_data, sb[0]);
    endtask

    initial begin
        vecs[0] = '{2'd0, 32'h0000_1234, 1'b0};
        vecs[1] = '{2'd1, 32'h2222_0001, 1'b0};
        vecs[2] = '{2'd2, 32'h3333_0002, 1'b0};
        vecs[3] = '{2'd3, 32'h0000_1234, 1'b1};
        vecs[4] = '{2'd1, 32'h2222_0001, 1'b0};

        bif4.in_data = '0; bif4.in_sel = '0; bif4.in_valid = 1'b0;
        bif4.flush = 1'b0; bif4.out_ready = 1'b0;
        bif3.in_data = {32'h3333_0002, 32'h2222_0001, 32'h0000_1234};
        bif3.in_sel = '0; bif3.in_valid = 1'b0;
        bif3.flush = 1'b0; bif3.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(bif4.out_valid), 0);
        chk("rst_out_data", bif4.out_data, 0);
        chk("rst_out_err", 32'(bif4.out_sel_err), 0);
        chk("rst_in_ready", 32'(bif4.in_ready), 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(bif4.in_ready), 1);

        // Back-to-back stream, no bubbles
        bif4.in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        bif4.out_ready = 1'b1;
        bif4.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bif4.in_sel = 2'(k);
            tick();
            chk("stream_valid", 32'(bif4.out_valid), 1);
            chk("stream_data", bif4.out_data, 32'hA0 + 32'(k));
            chk("stream_ready", 32'(bif4.in_ready), 1);
        end
        bif4.in_valid = 1'b0;
        tick();
        chk("stream_drain", 32'(bif4.out_valid), 0);

        // Select table on N=3, including the out-of-range index
        bif3.out_ready = 1'b1;
        bif3.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bif3.in_sel = vecs[i].sel;
            tick();
            chk("tbl_valid", 32'(bif3.out_valid), 1);
            chk("tbl_data", bif3.out_data, vecs[i].exp_data);
            chk("tbl_err", 32'(bif3.out_sel_err), 32'(vecs[i].exp_err));
        end
        // Hold an error word, then reset mid-operation
        bif3.in_sel = 2'd3;
        tick();
        bif3.in_valid = 1'b0;
        bif3.out_ready = 1'b0;
        tick();
        chk("held_err", 32'(bif3.out_sel_err), 1);
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(bif3.out_valid), 0);
        chk("midrst_data", bif3.out_data, 0);
        chk("midrst_err", 32'(bif3.out_sel_err), 0);
        chk("midrst_ready", 32'(bif3.in_ready), 0);
        rst = 1'b0;
        tick();

        // Stall: second word in skid, third held upstream, then FIFO release
        bif4.out_ready = 1'b0;
        bif4.in_valid = 1'b1;
        bif4.in_data = {4{32'h1111_0001}};
        tick();
        chk("stall_w1", bif4.out_data, 32'h1111_0001);
        chk("stall_rdy1", 32'(bif4.in_ready), 1);
        bif4.in_data = {4{32'h2222_0002}};
        tick();
        chk("stall_full_rdy", 32'(bif4.in_ready), 0);
        chk("stall_hold1", bif4.out_data, 32'h1111_0001);
        bif4.in_data = {4{32'h3333_0003}};
        tick();
        chk("stall_still_full", 32'(bif4.in_ready), 0);
        chk("stall_hold2", bif4.out_data, 32'h1111_0001);
        bif4.out_ready = 1'b1;
        tick();
        chk("release_w2", bif4.out_data, 32'h2222_0002);
        chk("release_rdy", 32'(bif4.in_ready), 1);
        tick();
        chk("release_w3", bif4.out_data, 32'h3333_0003);
        bif4.in_valid = 1'b0;
        tick();
        chk("release_empty", 32'(bif4.out_valid), 0);

        // Flush from FULL with a word offered
        bif4.out_ready = 1'b0;
        bif4.in_valid = 1'b1;
        bif4.in_data = {4{32'h4444_0001}};
        tick();
        bif4.in_data = {4{32'h4444_0002}};
        tick();
        chk("flush_pre_full", 32'(bif4.in_ready), 0);
        bif4.in_data = {4{32'h4444_0003}};
        bif4.flush = 1'b1;
        tick();
        chk("flush_valid", 32'(bif4.out_valid), 0);
        chk("flush_ready", 32'(bif4.in_ready), 1);
        bif4.flush = 1'b0;
        bif4.in_valid = 1'b0;
        tick();
        chk("flush_absent", 32'(bif4.out_valid), 0);

        // Flush beats a same-cycle accept from ONE
        bif4.in_valid = 1'b1;
        bif4.in_data = {4{32'h5555_0001}};
        tick();
        chk("fa_one", bif4.out_data, 32'h5555_0001);
        bif4.in_data = {4{32'h5555_0002}};
        bif4.flush = 1'b1;
        tick();
        chk("fa_flushed", 32'(bif4.out_valid), 0);
        bif4.flush = 1'b0;
        bif4.in_valid = 1'b0;
        tick();
        chk("fa_dropped", 32'(bif4.out_valid), 0);

        // Random traffic against the FIFO model
        sb.delete();
        for (int c = 0; c < 10000; c++)
            rnd_step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) != 0));
        for (int c = 0; c < 3; c++) rnd_step(1'b0, 1'b1);
        chk("rnd_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
